// File: rtl/upsp_stream_harness_pkg.sv
// Shared definitions for the upsampler stream harness: FSM states,
// pattern / backpressure mode codes, LFSR polynomial and the step
// functions for the LFSRs and the output checksum.
package upsp_stream_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // pat_mode codes
    localparam logic [1:0] PAT_RAMP    = 2'd0;
    localparam logic [1:0] PAT_CONST   = 2'd1;
    localparam logic [1:0] PAT_LFSR    = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    // bp_mode codes
    localparam logic [1:0] BP_READY    = 2'd0;
    localparam logic [1:0] BP_PERIODIC = 2'd1;
    localparam logic [1:0] BP_RANDOM   = 2'd2;
    localparam logic [1:0] BP_STUCK    = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Galois right-shift LFSR step
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Rotate-left-by-one then xor in the new beat
    function automatic logic [31:0] csum_step(input logic [31:0] c,
                                              input logic [31:0] d);
        return {c[30:0], c[31]} ^ d;
    endfunction

endpackage

// File: rtl/upsp_pattern_gen.sv
// Source pixel generator for the harness read stream.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear_i       restart the frame: x/y to 0, LFSR to seed
//   en_i          accepted read beat: advance x/y and LFSR
//   pat_mode_i    pixel pattern select
//   cfg_const_i   pixel value for the constant pattern
//   pixel_o       registered pixel for the current beat
module upsp_pattern_gen
    import upsp_stream_harness_pkg::*;
#(
    parameter int unsigned  CH        = 3,
    parameter int unsigned  CW        = 8,
    parameter int unsigned  SRC_W     = 960,
    parameter int unsigned  SRC_H     = 540,
    parameter logic [31:0]  LFSR_SEED = 32'h1,
    localparam int unsigned PIXEL_W   = CH * CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [1:0]         pat_mode_i,
    input  logic [PIXEL_W-1:0] cfg_const_i,
    output logic [PIXEL_W-1:0] pixel_o
);

    // At least 4 bits so the checker pattern can always look at bit 3
    localparam int unsigned XW = ($clog2(SRC_W) < 4) ? 4 : $clog2(SRC_W);
    localparam int unsigned YW = ($clog2(SRC_H) < 4) ? 4 : $clog2(SRC_H);

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;

    // Position / LFSR next state
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lfsr_d = lfsr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            lfsr_d = LFSR_SEED;
        end else if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
            if (x_q == XW'(SRC_W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(SRC_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Pixel is formed from the next position so it is ready with the beat
    always_comb begin
        pix_d = '0;
        case (pat_mode_i)
            PAT_RAMP: begin
                for (int c = 0; c < int'(CH); c++) begin
                    pix_d[c*CW +: CW] = CW'(32'(x_d) + 32'(y_d) + 32'(c));
                end
            end
            PAT_CONST: pix_d = cfg_const_i;
            PAT_LFSR:  pix_d = lfsr_d[PIXEL_W-1:0];
            default:   pix_d = (x_d[3] ^ y_d[3]) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            lfsr_q <= '0;
            pix_q  <= '0;
        end else if (clear_i || en_i) begin
            x_q    <= x_d;
            y_q    <= y_d;
            lfsr_q <= lfsr_d;
            pix_q  <= pix_d;
        end
    end

    assign pixel_o = pix_q;

endmodule

// File: rtl/upsp_stream_harness.sv
// Stimulus / monitor harness for the upsampler pixel streams.
// Drives the read stream with a selectable pattern, applies programmable
// backpressure on the write stream, counts and checksums output beats and
// reports done / timeout / overflow.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           begin a run (IDLE or DONE only)
//   pat_mode, cfg_const             read pattern select / constant value
//   bp_mode, bp_period, bp_low      write backpressure configuration
//   upsp_ac_rready, ac_upsp_rdata,
//   ac_upsp_rvalid                  read stream into the upsampler
//   upsp_ac_wdata, upsp_ac_wvalid,
//   ac_upsp_wready                  write stream out of the upsampler
//   busy, done, timeout, overflow   run status
//   in_cnt, out_cnt, checksum       run statistics
module upsp_stream_harness
    import upsp_stream_harness_pkg::*;
#(
    parameter int unsigned  CH        = 3,
    parameter int unsigned  CW        = 8,
    parameter int unsigned  SRC_W     = 960,
    parameter int unsigned  SRC_H     = 540,
    parameter int unsigned  SCALE     = 4,
    parameter int unsigned  TIMEOUT   = 1048576,
    parameter logic [31:0]  LFSR_SEED = 32'h1,
    localparam int unsigned PIXEL_W   = CH * CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         pat_mode,
    input  logic [PIXEL_W-1:0] cfg_const,
    input  logic [1:0]         bp_mode,
    input  logic [7:0]         bp_period,
    input  logic [7:0]         bp_low,
    input  logic               upsp_ac_rready,
    output logic [PIXEL_W-1:0] ac_upsp_rdata,
    output logic               ac_upsp_rvalid,
    output logic               ac_upsp_wready,
    input  logic [PIXEL_W-1:0] upsp_ac_wdata,
    input  logic               upsp_ac_wvalid,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               overflow,
    output logic [31:0]        in_cnt,
    output logic [31:0]        out_cnt,
    output logic [31:0]        checksum
);

    localparam logic [31:0] EXP_IN   = 32'(SRC_W * SRC_H);
    localparam logic [31:0] EXP_OUT  = 32'(SRC_W * SRC_H * SCALE * SCALE);
    localparam logic [31:0] IDLE_MAX = 32'(TIMEOUT - 1);

    state_e      state_q;
    logic        rvalid_q, wready_q, busy_q, done_q, timeout_q, overflow_q;
    logic [31:0] in_cnt_q, out_cnt_q, checksum_q, idle_q;
    logic [7:0]  ph_q;
    logic [31:0] bp_lfsr_q;

    logic        hs_r_c, hs_w_c, start_ok_c;
    logic [7:0]  bp_per_c, bp_lo_c, ph_nxt_c;
    logic [31:0] bp_lfsr_nxt_c;
    logic        wready_nxt_c;

    assign hs_r_c     = rvalid_q & upsp_ac_rready;
    assign hs_w_c     = wready_q & upsp_ac_wvalid;
    assign start_ok_c = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Source pixels
    upsp_pattern_gen #(
        .CH        (CH),
        .CW        (CW),
        .SRC_W     (SRC_W),
        .SRC_H     (SRC_H),
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_ok_c),
        .en_i        (hs_r_c),
        .pat_mode_i  (pat_mode),
        .cfg_const_i (cfg_const),
        .pixel_o     (ac_upsp_rdata)
    );

    // Backpressure generator: next phase / LFSR and the wready they imply
    always_comb begin
        bp_per_c      = (bp_period == 8'd0) ? 8'd1 : bp_period;
        bp_lo_c       = (bp_low > bp_per_c) ? bp_per_c : bp_low;
        ph_nxt_c      = '0;
        bp_lfsr_nxt_c = ~LFSR_SEED;
        if (!start_ok_c) begin
            ph_nxt_c      = (ph_q + 8'd1 >= bp_per_c) ? 8'd0 : ph_q + 8'd1;
            bp_lfsr_nxt_c = lfsr_step(bp_lfsr_q);
        end
        case (bp_mode)
            BP_READY:    wready_nxt_c = 1'b1;
            BP_PERIODIC: wready_nxt_c = (ph_nxt_c < (bp_per_c - bp_lo_c));
            BP_RANDOM:   wready_nxt_c = bp_lfsr_nxt_c[0];
            default:     wready_nxt_c = 1'b0;
        endcase
    end

    // Run control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            checksum_q <= '0;
            idle_q     <= '0;
            ph_q       <= '0;
            bp_lfsr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Late beats are flagged but never counted
                    if (state_q == ST_DONE && hs_w_c) begin
                        overflow_q <= 1'b1;
                    end
                    if (start_ok_c) begin
                        state_q    <= ST_RUN;
                        rvalid_q   <= 1'b1;
                        wready_q   <= wready_nxt_c;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        in_cnt_q   <= '0;
                        out_cnt_q  <= '0;
                        checksum_q <= '0;
                        idle_q     <= '0;
                        ph_q       <= ph_nxt_c;
                        bp_lfsr_q  <= bp_lfsr_nxt_c;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    ph_q      <= ph_nxt_c;
                    bp_lfsr_q <= bp_lfsr_nxt_c;
                    wready_q  <= wready_nxt_c;
                    if (hs_r_c) begin
                        in_cnt_q <= in_cnt_q + 32'd1;
                        if (in_cnt_q == EXP_IN - 32'd1) begin
                            rvalid_q <= 1'b0;
                            state_q  <= ST_DRAIN;
                        end
                    end
                    if (hs_w_c) begin
                        out_cnt_q  <= out_cnt_q + 32'd1;
                        checksum_q <= csum_step(checksum_q, 32'(upsp_ac_wdata));
                    end
                    idle_q <= (hs_r_c | hs_w_c) ? 32'd0 : idle_q + 32'd1;
                    // Completion takes priority over the idle timer
                    if (hs_w_c && out_cnt_q == EXP_OUT - 32'd1) begin
                        state_q  <= ST_DONE;
                        rvalid_q <= 1'b0;
                        wready_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (!hs_r_c && !hs_w_c && idle_q == IDLE_MAX) begin
                        state_q   <= ST_DONE;
                        rvalid_q  <= 1'b0;
                        wready_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ac_upsp_rvalid = rvalid_q;
    assign ac_upsp_wready = wready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign overflow       = overflow_q;
    assign in_cnt         = in_cnt_q;
    assign out_cnt        = out_cnt_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_upsp_stream_harness.sv
// Directed bench for upsp_stream_harness with a stub upsampler that
// repeats every accepted read pixel four times on the write stream.
module tb_upsp_stream_harness;

    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    pat_mode = 2'd0;
    logic [PW-1:0] cfg_const = '0;
    logic [1:0]    bp_mode = 2'd0;
    logic [7:0]    bp_period = 8'd0;
    logic [7:0]    bp_low = 8'd0;
    logic          rready;
    logic [PW-1:0] rdata;
    logic          rvalid;
    logic          wready;
    logic [PW-1:0] wdata;
    logic          wvalid;
    logic          busy, done, timeout, overflow;
    logic [31:0]   in_cnt, out_cnt, checksum;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    upsp_stream_harness #(
        .CH(3), .CW(8), .SRC_W(4), .SRC_H(2), .SCALE(2),
        .TIMEOUT(64), .LFSR_SEED(32'h1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pat_mode       (pat_mode),
        .cfg_const      (cfg_const),
        .bp_mode        (bp_mode),
        .bp_period      (bp_period),
        .bp_low         (bp_low),
        .upsp_ac_rready (rready),
        .ac_upsp_rdata  (rdata),
        .ac_upsp_rvalid (rvalid),
        .ac_upsp_wready (wready),
        .upsp_ac_wdata  (wdata),
        .upsp_ac_wvalid (wvalid),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .overflow       (overflow),
        .in_cnt         (in_cnt),
        .out_cnt        (out_cnt),
        .checksum       (checksum)
    );

    // Stub upsampler: FIFO of read pixels, each emitted 4 times
    logic [PW-1:0] smem [16];
    logic [3:0]    swp, srp, socc;
    logic [1:0]    srep;
    logic          stub_wvalid;
    logic          rready_en = 1'b1;
    logic          force_wv = 1'b0;

    assign socc        = swp - srp;
    assign stub_wvalid = (socc != 4'd0);
    assign rready      = rready_en && (socc < 4'd12);
    assign wvalid      = stub_wvalid | force_wv;
    assign wdata       = force_wv ? 24'hABCDEF : smem[srp];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swp  <= '0;
            srp  <= '0;
            srep <= '0;
        end else begin
            if (rvalid && rready) begin
                smem[swp] <= rdata;
                swp       <= swp + 4'd1;
            end
            if (stub_wvalid && wready && !force_wv) begin
                srep <= srep + 2'd1;
                if (srep == 2'd3) srp <= srp + 4'd1;
            end
        end
    end

    // Expected checksum of the ramp frame, each pixel repeated 4 times
    function automatic logic [31:0] ramp_csum();
        logic [31:0] c;
        logic [23:0] p;
        c = '0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                p = {8'(x + y + 2), 8'(x + y + 1), 8'(x + y)};
                for (int r = 0; r < 4; r++) c = {c[30:0], c[31]} ^ {8'h00, p};
            end
        end
        return c;
    endfunction

    logic [31:0] exp_csum;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in the first RUN cycle
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            step();
        end
    endtask

    task automatic test_reset();
        if ({rdata, rvalid, wready, busy, done, timeout, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags got rdata=%h rv=%b wr=%b busy=%b done=%b to=%b ov=%b want all 0",
                     rdata, rvalid, wready, busy, done, timeout, overflow);
        end
        n_cmp++;
        if ({in_cnt, out_cnt, checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters got in=%0d out=%0d cs=%h want 0", in_cnt, out_cnt, checksum);
        end
        n_cmp++;
    endtask

    task automatic test_ramp();
        pat_mode = 2'd0; bp_mode = 2'd0;
        pulse_start();
        if (rdata !== 24'h020100 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_first got rdata=%h rv=%b want 020100 1", rdata, rvalid);
        end
        n_cmp++;
        if (wready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_first_ctrl got wr=%b busy=%b want 1 1", wready, busy);
        end
        n_cmp++;
        wait_done(500);
        if (done !== 1'b1 || timeout !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_flags got done=%b to=%b ov=%b busy=%b want 1 0 0 0", done, timeout, overflow, busy);
        end
        n_cmp++;
        if (in_cnt !== 32'd8 || out_cnt !== 32'd32) begin
            n_fail++;
            $display("FAIL ramp_counts got in=%0d out=%0d want 8 32", in_cnt, out_cnt);
        end
        n_cmp++;
        if (checksum !== exp_csum) begin
            n_fail++;
            $display("FAIL ramp_checksum got %h want %h", checksum, exp_csum);
        end
        n_cmp++;
    endtask

    task automatic test_overflow();
        force_wv = 1'b1;
        step();
        force_wv = 1'b0;
        step();
        if (overflow !== 1'b1 || out_cnt !== 32'd32 || checksum !== exp_csum) begin
            n_fail++;
            $display("FAIL overflow got ov=%b out=%0d cs=%h want 1 32 %h", overflow, out_cnt, checksum, exp_csum);
        end
        n_cmp++;
    endtask

    task automatic test_stall();
        pat_mode = 2'd0; bp_mode = 2'd0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (in_cnt == 32'd2) break;
            step();
        end
        rready_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rdata !== 24'h040302 || in_cnt !== 32'd2 || rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got rdata=%h in=%0d rv=%b want 040302 2 1", i, rdata, in_cnt, rvalid);
            end
            n_cmp++;
            start = (i == 2);
            step();
        end
        start = 1'b0;
        if (rdata !== 24'h040302 || in_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_start_ignored got rdata=%h in=%0d want 040302 2", rdata, in_cnt);
        end
        n_cmp++;
        rready_en = 1'b1;
        wait_done(500);
        if (done !== 1'b1 || in_cnt !== 32'd8 || out_cnt !== 32'd32 || checksum !== exp_csum) begin
            n_fail++;
            $display("FAIL stall_end got done=%b in=%0d out=%0d cs=%h want 1 8 32 %h", done, in_cnt, out_cnt, checksum, exp_csum);
        end
        n_cmp++;
    endtask

    task automatic test_bp_periodic();
        logic [7:0] pat;
        pat = 8'b0111_0111;  // bit i = expected wready in RUN cycle i
        pat_mode = 2'd0; bp_mode = 2'd1; bp_period = 8'd4; bp_low = 8'd1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (wready !== pat[i]) begin
                n_fail++;
                $display("FAIL bp_periodic_wready[%0d] got %b want %b", i, wready, pat[i]);
            end
            n_cmp++;
            step();
        end
        wait_done(500);
        if (done !== 1'b1 || out_cnt !== 32'd32 || checksum !== exp_csum) begin
            n_fail++;
            $display("FAIL bp_periodic_end got done=%b out=%0d cs=%h want 1 32 %h", done, out_cnt, checksum, exp_csum);
        end
        n_cmp++;
    endtask

    task automatic test_lfsr();
        pat_mode = 2'd2; bp_mode = 2'd0;
        pulse_start();
        if (rdata !== 24'h000001) begin
            n_fail++;
            $display("FAIL lfsr_beat0 got %h want 000001", rdata);
        end
        n_cmp++;
        step();
        if (rdata !== 24'h200003 || in_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL lfsr_beat1 got %h in=%0d want 200003 1", rdata, in_cnt);
        end
        n_cmp++;
        wait_done(500);
        if (done !== 1'b1 || out_cnt !== 32'd32) begin
            n_fail++;
            $display("FAIL lfsr_end got done=%b out=%0d want 1 32", done, out_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_timeout();
        int last, n;
        pat_mode = 2'd0; bp_mode = 2'd3;
        pulse_start();
        if (wready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_stuck_wready got %b want 0", wready);
        end
        n_cmp++;
        last = 0;
        n = 0;
        while (n < 400 && done !== 1'b1) begin
            if ((rvalid && rready) || (wvalid && wready)) last = n;
            step();
            n++;
        end
        if (n - last !== 65) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d want 65", n - last);
        end
        n_cmp++;
        if (done !== 1'b1 || timeout !== 1'b1 || in_cnt !== 32'd8 || out_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_flags got done=%b to=%b in=%0d out=%0d want 1 1 8 0", done, timeout, in_cnt, out_cnt);
        end
        n_cmp++;
        for (int i = 0; i < 5; i++) step();
        if (overflow !== 1'b1 || out_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_late_beats got ov=%b out=%0d want 1 0", overflow, out_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_midrun_reset();
        pat_mode = 2'd0; bp_mode = 2'd0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (in_cnt == 32'd3) break;
            step();
        end
        rst_n = 1'b0;
        #1;
        if ({rdata, rvalid, wready, busy, done, timeout, overflow, in_cnt, out_cnt, checksum} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset got rdata=%h rv=%b wr=%b busy=%b done=%b in=%0d out=%0d cs=%h want all 0",
                     rdata, rvalid, wready, busy, done, in_cnt, out_cnt, checksum);
        end
        n_cmp++;
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        if (rdata !== 24'h020100 || in_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL restart_first got rdata=%h in=%0d want 020100 0", rdata, in_cnt);
        end
        n_cmp++;
        wait_done(500);
        if (done !== 1'b1 || in_cnt !== 32'd8 || out_cnt !== 32'd32 || checksum !== exp_csum) begin
            n_fail++;
            $display("FAIL restart_end got done=%b in=%0d out=%0d cs=%h want 1 8 32 %h", done, in_cnt, out_cnt, checksum, exp_csum);
        end
        n_cmp++;
    endtask

    initial begin
        exp_csum = ramp_csum();
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_ramp();
        test_overflow();
        test_stall();
        test_bp_periodic();
        test_lfsr();
        test_timeout();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/upsp_stream_harness.md
# upsp_stream_harness

Synthesizable, parametrised stimulus and monitor harness for the upsampler's AC-side pixel streams. It supersedes hand-timed testbench stimulus. It drives the read stream into the upsampler with a selectable pixel pattern, applies programmable backpressure on the write stream, and counts and checksums every output beat. It flags completion or timeout, so one bench or an FPGA self-test wrapper can exercise any bicubic_top configuration.

## Interface
Parameters:
- CH, 3, colour channels per pixel
- CW, 8, bits per channel; PIXEL_W = CH*CW, at most 32
- SRC_W, 960, source frame width (pixels)
- SRC_H, 540, source frame height (lines)
- SCALE, 4, upscale factor per axis; expected outputs = SRC_W*SRC_H*SCALE*SCALE
- TIMEOUT, 1048576, idle cycles before abort
- LFSR_SEED, 32'h1, seed for pattern and backpressure LFSRs; must be non-zero

Ports:
- clk  in  1  clock; one clock domain, asynchronous active-low reset
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- pat_mode  in  2  0 ramp, 1 constant, 2 LFSR, 3 checker
- cfg_const  in  PIXEL_W  pixel value for pat_mode 1
- bp_mode  in  2  0 always ready, 1 periodic, 2 LFSR-random, 3 stuck low
- bp_period  in  8  periodic backpressure period in cycles, 0 treated as 1
- bp_low  in  8  low cycles per period, clamped to bp_period
- upsp_ac_rready  in  1  upsampler accepts read beat
- ac_upsp_rdata  out  PIXEL_W  source pixel
- ac_upsp_rvalid  out  1  source pixel valid
- ac_upsp_wready  out  1  harness accepts output beat
- upsp_ac_wdata  in  PIXEL_W  upscaled pixel
- upsp_ac_wvalid  in  1  upscaled pixel valid
- busy  out  1  state is RUN or DRAIN
- done  out  1  run finished; held until the next start
- timeout  out  1  run aborted by idle timer
- overflow  out  1  output beat arrived after the expected count was reached
- in_cnt  out  32  accepted read beats
- out_cnt  out  32  accepted write beats
- checksum  out  32  running output checksum

## Operation
- FSM IDLE → RUN → DRAIN → DONE.
- IDLE or DONE with start: clear counters, checksum, flags and x/y; reseed both LFSRs; go to RUN.
- RUN: rvalid=1. A read beat is accepted when rvalid&&rready; the beat advances x, y and in_cnt.
- RUN: rdata/rvalid hold stable while rvalid&&!rready. After the last beat (in_cnt = SRC_W*SRC_H) go to DRAIN with rvalid=0.
- Pixel patterns, per channel c (channel 0 = LSBs):
  - ramp: (x+y+c) mod 2^CW
  - constant: cfg_const
  - LFSR: low PIXEL_W bits of a 32-bit Galois right-shift LFSR, poly 32'h80200003, advanced per accepted beat
  - checker: all-ones if x[3]^y[3], else zero
- Write beat accepted when wvalid&&wready: out_cnt++, checksum = {checksum[30:0],checksum[31]} ^ zero-extended wdata.
- Reaching the expected count moves RUN or DRAIN to DONE. In DONE, wready stays 1 and any further beat sets sticky overflow; the beat does not count.
- Idle timer: reset by any handshake, increments otherwise in RUN or DRAIN. At TIMEOUT it forces DONE with timeout=1.
- Backpressure generator runs only in RUN or DRAIN:
  - mode 1: wready low for the last bp_low cycles of each bp_period
  - mode 2: bit 0 of a second LFSR (seed ~LFSR_SEED)
  - mode 3: wready=0

## Timing
- All outputs are registered. Reset value 0 for every output, including rdata.
- rvalid rises and the first rdata appears the cycle after start is sampled; wready is also valid from that cycle.
- done/timeout assert the cycle after the terminating handshake or timer hit.
- A read and a write handshake in the same cycle are both counted.
- start while busy is ignored. start in the same cycle as entering DONE is ignored.
- rst_n low mid-run: immediate return to IDLE, all outputs 0, no residual state.

## Structure
- Shared definitions file upsp_harness_defs holds: FSM state encodings, pat_mode/bp_mode codes, LFSR polynomial, checksum rotate-xor function.
- Sub-module upsp_pattern_gen: x/y counters, pattern LFSR and pixel formation, with enable = accepted beat.

## Test plan
Use SRC_W=4, SRC_H=2, SCALE=2, CH=3, CW=8 and a stub DUT that emits each input 4 times.
- Ramp, bp_mode 0 → first rdata 24'h020100; in_cnt=8, out_cnt=32, done=1, timeout=0, overflow=0.
- rready held low 5 cycles while rvalid=1 → rdata unchanged, in_cnt unchanged, no lost beat.
- bp_mode 1, period 4, low 1 → wready pattern 1,1,1,0 repeating; out_cnt=32, checksum identical to the bp_mode 0 run.
- bp_mode 3, TIMEOUT=64 → done=1, timeout=1 exactly 65 cycles after the last handshake.
- LFSR pattern, seed 1 → rdata beats 24'h000001 then 24'h200003.
- rst_n low at in_cnt=3 → all outputs 0 at once; a new start yields first rdata 24'h020100, in_cnt from 0.
